// File: rtl/nco_pkg.sv
// Shared types for the NCO sweep controller: FSM state encoding and
// sweep mode constants.
package nco_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP_UP  = 3'd1,
    S_DWELL_HI = 3'd2,
    S_RAMP_DN  = 3'd3,
    S_DWELL_LO = 3'd4
  } sweep_state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_TRI    = 1'b1;

endpackage

// File: rtl/nco_sat_step.sv
// Saturating add/sub of a step onto a frequency word, clamped to a bound.
// Ports: a (current word), b (step), bound (clamp), sub (1 = subtract),
// result (next word), hit (bound reached; result equals bound).
module nco_sat_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] bound,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         hit
);

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit catches carry/borrow so the word never wraps.
  // A zero step jumps straight to the bound.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    if (sub) begin
      hit = diff[W]
         || (diff[W-1:0] <= bound)
         || (b == '0);
    end else begin
      hit = (sum >= {1'b0, bound})
         || (b == '0);
    end
    if (hit) begin
      result = bound;
    end else if (sub) begin
      result = diff[W-1:0];
    end else begin
      result = sum[W-1:0];
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Chirp controller ramping the NCO phase increment between two words.
// Ports: clk_i, rst_n, cfg_* handshake + sweep config, abort_i,
// acc_o (freq word), busy_o, dir_o, done_o.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [ACC_WIDTH-1:0] f_start_i,
  input  logic [ACC_WIDTH-1:0] f_stop_i,
  input  logic [ACC_WIDTH-1:0] step_i,
  input  logic [CNT_WIDTH-1:0] dwell_i,
  input  logic                 mode_i,
  input  logic                 abort_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 busy_o,
  output logic                 dir_o,
  output logic                 done_o
);

  sweep_state_t         state;
  logic [ACC_WIDTH-1:0] f_start_q;
  logic [ACC_WIDTH-1:0] f_hi_q;
  logic [ACC_WIDTH-1:0] step_q;
  logic [CNT_WIDTH-1:0] dwell_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 down;
  logic [ACC_WIDTH-1:0] bound;
  logic [ACC_WIDTH-1:0] nxt;
  logic                 hit;

  assign down  = (state == S_RAMP_DN);
  assign bound = down ? f_start_q : f_hi_q;

  nco_sat_step #(
    .W(ACC_WIDTH)
  ) u_step (
    .a      (acc_o),
    .b      (step_q),
    .bound  (bound),
    .sub    (down),
    .result (nxt),
    .hit    (hit)
  );

  assign cfg_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);

  // Dwell states last max(dwell,1) cycles: the counter is loaded on
  // entry and the state is left once it is at or below one.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f_start_q <= '0;
      f_hi_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_SINGLE;
      cnt       <= '0;
      acc_o     <= '0;
      dir_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == S_IDLE) begin
        if (cfg_valid_i) begin
          f_start_q <= f_start_i;
          f_hi_q    <= (f_start_i > f_stop_i)
                     ? f_start_i : f_stop_i;
          step_q    <= step_i;
          dwell_q   <= dwell_i;
          mode_q    <= mode_i;
          acc_o     <= f_start_i;
          dir_o     <= 1'b0;
          state     <= S_RAMP_UP;
        end
      end else if (abort_i) begin
        state <= S_IDLE;
        dir_o <= 1'b0;
      end else begin
        unique case (state)
          S_RAMP_UP: begin
            acc_o <= nxt;
            if (hit) begin
              state <= S_DWELL_HI;
              cnt   <= dwell_q;
            end
          end
          S_DWELL_HI: begin
            if (cnt <= CNT_WIDTH'(1)) begin
              if (mode_q == MODE_TRI) begin
                state <= S_RAMP_DN;
                dir_o <= 1'b1;
              end else begin
                state  <= S_IDLE;
                done_o <= 1'b1;
              end
            end else begin
              cnt <= cnt - CNT_WIDTH'(1);
            end
          end
          S_RAMP_DN: begin
            acc_o <= nxt;
            if (hit) begin
              state <= S_DWELL_LO;
              cnt   <= dwell_q;
            end
          end
          S_DWELL_LO: begin
            if (cnt <= CNT_WIDTH'(1)) begin
              state <= S_RAMP_UP;
              dir_o <= 1'b0;
            end else begin
              cnt <= cnt - CNT_WIDTH'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            dir_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against a trace model built from the sweep rules.
module tb_nco_sweep_ctrl;

  localparam int AW = 32;
  localparam int CW = 16;
  localparam longint TOP = 64'h0000_0000_FFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [AW-1:0] f_start_i = '0;
  logic [AW-1:0] f_stop_i = '0;
  logic [AW-1:0] step_i = '0;
  logic [CW-1:0] dwell_i = '0;
  logic          mode_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] acc_o;
  logic          busy_o;
  logic          dir_o;
  logic          done_o;

  nco_sweep_ctrl #(
    .ACC_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .f_start_i   (f_start_i),
    .f_stop_i    (f_stop_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .mode_i      (mode_i),
    .abort_i     (abort_i),
    .acc_o       (acc_o),
    .busy_o      (busy_o),
    .dir_o       (dir_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    longint acc;
    bit     dir;
    bit     busy;
    bit     done;
  } exp_t;

  exp_t tr[$];

  function automatic void push(longint a, bit d, bit b, bit dn);
    exp_t e;
    e.acc  = a;
    e.dir  = d;
    e.busy = b;
    e.done = dn;
    tr.push_back(e);
  endfunction

  // Expected per-cycle trace, index 0 = first cycle after acceptance.
  // Each ramp lists its values from the turn point up to the clamped
  // end point; the end point is then held for max(dwell,1) cycles.
  function automatic void build(longint s, longint p, longint st,
                                int d, bit m, int n);
    longint hi;
    longint v;
    int     hold;
    hi   = (s > p) ? s : p;
    hold = (d < 1) ? 1 : d;
    tr.delete();
    while (tr.size() < n) begin
      v = s;
      push(v, 0, 1, 0);
      forever begin
        v = v + st;
        if (v >= hi || st == 0) begin
          push(hi, 0, 1, 0);
          break;
        end
        push(v, 0, 1, 0);
      end
      repeat (hold - 1) push(hi, 0, 1, 0);
      if (!m) begin
        push(hi, 0, 0, 1);
        while (tr.size() < n) push(hi, 0, 0, 0);
        break;
      end
      v = hi;
      push(v, 1, 1, 0);
      forever begin
        v = v - st;
        if (v <= s || st == 0) begin
          push(s, 1, 1, 0);
          break;
        end
        push(v, 1, 1, 0);
      end
      repeat (hold - 1) push(s, 1, 1, 0);
    end
  endfunction

  task automatic run(string nm, longint s, longint p, longint st,
                     int d, bit m, int n, int ab, bit acc_ab);
    exp_t   e;
    bit     aborted;
    longint frz;
    aborted = 0;
    frz     = 0;
    build(s, p, st, d, m, n);
    @(negedge clk_i);
    chk({nm, ":ready"}, {63'b0, cfg_ready_o}, 64'd1);
    f_start_i   = s[AW-1:0];
    f_stop_i    = p[AW-1:0];
    step_i      = st[AW-1:0];
    dwell_i     = CW'(d);
    mode_i      = m;
    cfg_valid_i = 1'b1;
    abort_i     = acc_ab;
    @(negedge clk_i);
    for (int i = 0; i < n; i++) begin
      if (aborted) begin
        e.acc  = frz;
        e.dir  = 0;
        e.busy = 0;
        e.done = 0;
      end else begin
        e = tr[i];
      end
      chk($sformatf("%s:acc[%0d]", nm, i),
          {32'b0, acc_o}, 64'(e.acc));
      chk($sformatf("%s:flags[%0d]", nm, i),
          {60'b0, dir_o, busy_o, done_o, cfg_ready_o},
          {60'b0, e.dir, e.busy, e.done, !e.busy});
      if (i == ab && e.busy) begin
        aborted = 1;
        frz     = e.acc;
      end
      abort_i     = (i == ab);
      cfg_valid_i = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      f_start_i   = $urandom;
      f_stop_i    = $urandom;
      step_i      = $urandom;
      dwell_i     = CW'($urandom);
      mode_i      = 1'($urandom_range(0, 1));
      @(negedge clk_i);
    end
    abort_i     = 1'b0;
    cfg_valid_i = 1'b0;
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk_i);
    f_start_i   = 32'd100;
    f_stop_i    = 32'd900;
    step_i      = 32'd10;
    dwell_i     = '0;
    mode_i      = 1'b1;
    cfg_valid_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst:pre_busy", {63'b0, busy_o}, 64'd1);
    chk("rst:pre_acc", {32'b0, acc_o}, 64'd110);
    #2 rst_n = 1'b0;
    #1;
    chk("rst:acc", {32'b0, acc_o}, 64'd0);
    chk("rst:flags", {60'b0, dir_o, busy_o, done_o, cfg_ready_o},
        64'b0001);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    longint s;
    longint p;
    longint st;
    int     d;
    bit     m;
    int     ab;
    bit     aa;
    rst_n = 1'b0;
    #12;
    chk("reset:acc", {32'b0, acc_o}, 64'd0);
    chk("reset:flags", {60'b0, dir_o, busy_o, done_o, cfg_ready_o},
        64'b0001);
    @(negedge clk_i);
    rst_n = 1'b1;

    run("t1", 100, 130, 10, 0, 0, 8, 6, 0);
    run("t2", 100, 125, 10, 2, 0, 10, 8, 0);
    run("t3", 0, 20, 10, 1, 1, 14, 12, 0);
    run("t4", 0, 20, 10, 1, 1, 8, 4, 0);
    run("t5clamp", 64'hFFFF_FFF0, TOP, 20, 0, 0, 5, 3, 0);
    run("t5step0", 64'hFFFF_FFF0, TOP, 0, 0, 0, 5, 3, 0);
    run("zerolen", 500, 200, 7, 0, 1, 10, 8, 1);
    reset_mid_sweep();

    for (int k = 0; k < 30; k++) begin
      st = ($urandom_range(0, 9) == 0)
         ? 0 : longint'($urandom_range(1, 5000));
      if ($urandom_range(0, 3) == 0)
        s = TOP - longint'($urandom_range(0, 20000));
      else
        s = longint'($urandom);
      if ($urandom_range(0, 3) == 0)
        p = longint'($urandom);
      else begin
        p = s + longint'($urandom_range(0, 6 * 5000 + 1)) % (6 * st + 2);
        if (p > TOP) p = TOP;
      end
      d  = $urandom_range(0, 3);
      m  = (st == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 38) : 38;
      aa = ($urandom_range(0, 3) == 0);
      run($sformatf("rnd%0d", k), s, p, st, d, m, 40, ab, aa);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
